// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
// Shared EXE-stage definitions: ALU control codes (shared with the ALU control
// decoder), the multiplier state enum and the default datapath width.
// -----------------------------------------------------------------------------
package exe_pkg;

    localparam int XLEN_DEF = 32;

    // ALU control codes (5-bit decoded operation)
    localparam logic [4:0] ALU_add    = 5'd0;
    localparam logic [4:0] ALU_sub    = 5'd1;
    localparam logic [4:0] ALU_and    = 5'd2;
    localparam logic [4:0] ALU_or     = 5'd3;
    localparam logic [4:0] ALU_xor    = 5'd4;
    localparam logic [4:0] ALU_sll    = 5'd5;
    localparam logic [4:0] ALU_srl    = 5'd6;
    localparam logic [4:0] ALU_sra    = 5'd7;
    localparam logic [4:0] ALU_slt    = 5'd8;
    localparam logic [4:0] ALU_sltu   = 5'd9;
    localparam logic [4:0] ALU_mul    = 5'd10;
    localparam logic [4:0] ALU_mulh   = 5'd11;
    localparam logic [4:0] ALU_mulhsu = 5'd12;
    localparam logic [4:0] ALU_mulhu  = 5'd13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    function automatic logic is_mul_op(input logic [4:0] ctrl);
        return (ctrl >= ALU_mul) && (ctrl <= ALU_mulhu);
    endfunction

endpackage

// File: rtl/exe_mul_datapath.sv
// -----------------------------------------------------------------------------
// exe_mul_datapath
// Shift-add multiply datapath: operand registers, 2*XLEN accumulator with a
// carry bit, final two's-complement negation and the result register.
// Sequencing comes entirely from exe_mul_unit.
//   clk, rst     : clock, synchronous active-high reset
//   i_load       : capture operand magnitudes, clear accumulator
//   i_step       : perform one shift-add step
//   i_finish     : load result from (optionally negated) product
//   i_neg        : product must be negated
//   i_sel_hi     : result takes upper half of product (else lower half)
//   i_mcand      : multiplicand magnitude
//   i_mplier     : multiplier magnitude
//   o_result     : registered product slice
// -----------------------------------------------------------------------------
module exe_mul_datapath
    import exe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic            i_step,
    input  logic            i_finish,
    input  logic            i_neg,
    input  logic            i_sel_hi,
    input  logic [XLEN-1:0] i_mcand,
    input  logic [XLEN-1:0] i_mplier,
    output logic [XLEN-1:0] o_result
);

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;

    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_acc_step;
    logic [2*XLEN-1:0] w_product;

    // Upper half gains the multiplicand when the current multiplier bit is set;
    // the carry out re-enters at the top as {carry, acc} shifts right by one.
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]}
                      + {1'b0, (r_mplier[0] ? r_mcand : {XLEN{1'b0}})};
    assign w_acc_step = {w_sum, r_acc[XLEN-1:1]};
    assign w_product  = i_neg ? neg_wide(r_acc) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (i_load) begin
                r_mcand  <= i_mcand;
                r_mplier <= i_mplier;
                r_acc    <= '0;
            end else if (i_step) begin
                r_acc    <= w_acc_step;
                r_mplier <= r_mplier >> 1;
            end
            if (i_finish) begin
                r_result <= i_sel_hi ? w_product[2*XLEN-1:XLEN] : w_product[XLEN-1:0];
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/exe_mul_unit.sv
// -----------------------------------------------------------------------------
// exe_mul_unit
// Iterative 32-step shift-add multiplier for MUL/MULH/MULHSU/MULHU. Holds the
// pipeline via busy while working, then pulses done for one cycle with the
// registered result.
//   clk       : clock
//   rst       : synchronous active-high reset
//   start     : EXE stage holds a valid instruction
//   ALU_ctrl  : decoded ALU operation
//   rs1_data  : multiplicand
//   rs2_data  : multiplier
//   flush     : kill in-flight operation
//   busy      : stall request (combinational)
//   done      : one-cycle result-valid pulse (registered)
//   result    : registered product slice
// -----------------------------------------------------------------------------
module exe_mul_unit
    import exe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      ALU_ctrl,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    // Magnitude of a possibly-signed operand; the most negative value maps to
    // 2^(XLEN-1), which still fits as an unsigned XLEN-bit number.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic s);
        return s ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    mul_state_e       r_state;
    mul_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic             r_sel_hi;
    logic             r_done;

    logic             w_is_mul;
    logic             w_accept;
    logic             w_sign_a;
    logic             w_sign_b;

    assign w_is_mul = is_mul_op(ALU_ctrl);
    assign w_accept = (r_state == IDLE) && start && w_is_mul && !flush;
    assign w_sign_a = ((ALU_ctrl == ALU_mulh) || (ALU_ctrl == ALU_mulhsu)) && rs1_data[XLEN-1];
    assign w_sign_b = (ALU_ctrl == ALU_mulh) && rs2_data[XLEN-1];

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_next = CALC;
                CALC: if (r_cnt == CNT_LAST) w_next = SIGN;
                SIGN: w_next = DONE;
                DONE: w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_sel_hi <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            // done is raised on the SIGN->DONE edge; a flush in SIGN suppresses it
            r_done  <= (r_state == SIGN) && !flush;
            if (w_accept) begin
                r_cnt    <= '0;
                r_neg    <= w_sign_a ^ w_sign_b;
                r_sel_hi <= (ALU_ctrl != ALU_mul);
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    exe_mul_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_accept),
        .i_step   ((r_state == CALC) && !flush),
        .i_finish ((r_state == SIGN) && !flush),
        .i_neg    (r_neg),
        .i_sel_hi (r_sel_hi),
        .i_mcand  (magnitude(rs1_data, w_sign_a)),
        .i_mplier (magnitude(rs2_data, w_sign_b)),
        .o_result (result)
    );

    assign busy = (r_state == CALC) || (r_state == SIGN) || w_accept;
    assign done = r_done;

endmodule

// File: tb/tb_exe_mul_unit.sv
module tb_exe_mul_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  ALU_ctrl;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    exe_mul_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ALU_ctrl (ALU_ctrl),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width product by ordinary arithmetic on extended operands.
    function automatic logic [31:0] model(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (ctrl == 5'd11 || ctrl == 5'd12) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (ctrl == 5'd11) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (ctrl == 5'd10) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation and verify busy/done timing and the result.
    task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input bit hold);
        logic [31:0] exp;
        int bad;
        exp = model(ctrl, a, b);
        @(negedge clk);
        start = 1'b1; ALU_ctrl = ctrl; rs1_data = a; rs2_data = b;
        #1;
        check({tag, " busy@accept"}, {31'd0, busy}, 32'd1);
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            rs1_data = $urandom; rs2_data = $urandom;
            #1;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
        end
        check({tag, " busy/done during calc"}, bad, 0);
        @(negedge clk);
        #1;
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
        check({tag, " result"}, result, exp);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, " done after"}, {31'd0, done}, 32'd0);
        check({tag, " result held"}, result, exp);
    endtask

    initial begin
        logic [31:0] prev;
        logic [4:0]  rc;
        logic [31:0] ra, rb;
        int cnt;
        logic [31:0] corner [6];
        corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h0000_0001; corner[5] = 32'h0000_0002;

        rst = 1'b1; start = 1'b0; ALU_ctrl = 5'd0; rs1_data = '0; rs2_data = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors
        run_op("MUL 7x6", 5'd10, 32'd7, 32'd6, 1'b0);
        check("MUL 7x6 const", result, 32'h0000_002A);
        run_op("MULH -1x-1", 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("MULH -1x-1 const", result, 32'h0000_0000);
        run_op("MULH min x min", 5'd11, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("MULH min x min const", result, 32'h4000_0000);
        run_op("MULHSU -1 x max", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("MULHSU const", result, 32'hFFFF_FFFF);
        run_op("MULHU max x max", 5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("MULHU const", result, 32'hFFFF_FFFE);
        run_op("MUL min x 2", 5'd10, 32'h8000_0000, 32'd2, 1'b0);
        check("MUL min x 2 const", result, 32'h0000_0000);
        run_op("MULH -3x5", 5'd11, 32'hFFFF_FFFD, 32'd5, 1'b0);

        // Flush at the 10th CALC cycle
        prev = result;
        @(negedge clk);
        start = 1'b1; ALU_ctrl = 5'd10; rs1_data = 32'd9; rs2_data = 32'd9;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush busy next", {31'd0, busy}, 32'd0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) cnt++;
        end
        check("flush no done", cnt, 0);
        check("flush result kept", result, prev);
        run_op("MUL 3x5 after flush", 5'd10, 32'd3, 32'd5, 1'b0);
        check("MUL 3x5 const", result, 32'd15);

        // Abort via reset
        @(negedge clk);
        start = 1'b1; ALU_ctrl = 5'd13; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst abort busy", {31'd0, busy}, 32'd0);
        check("rst abort result", result, 32'd0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (done !== 1'b0) cnt++;
        end
        check("rst abort no done", cnt, 0);

        // Non-mul codes are ignored
        @(negedge clk);
        start = 1'b1; ALU_ctrl = 5'd0; rs1_data = 32'd4; rs2_data = 32'd4;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1; if (busy !== 1'b0 || done !== 1'b0) cnt++;
            @(negedge clk);
        end
        check("ADD ignored", cnt, 0);
        ALU_ctrl = 5'd14;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1; if (busy !== 1'b0 || done !== 1'b0) cnt++;
            @(negedge clk);
        end
        check("ctrl14 ignored", cnt, 0);

        // start with flush in IDLE is not accepted
        ALU_ctrl = 5'd10; flush = 1'b1;
        #1;
        check("flush+start busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) cnt++;
        end
        check("flush+start not accepted", cnt, 0);

        // start held high through DONE: exactly one pulse
        run_op("MUL held start", 5'd10, 32'd1000, 32'd77, 1'b1);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk); #1;
            if (busy !== 1'b0 || done !== 1'b0) cnt++;
        end
        check("held start single pulse", cnt, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            rc = 5'($urandom_range(10, 13));
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            run_op($sformatf("rand%0d op%0d %h*%h", i, rc, ra, rb), rc, ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
